// File: rtl/nn_frame_sequencer_if.sv
// Stream, array-side and result signals between the frame sequencer and its environment.
// The slave modport is the sequencer. The master modport is the upstream source, the MAIN array and the result sink.
interface nn_frame_sequencer_if #(
   parameter int DEP = 8,
   parameter int COL = 1,
   parameter int FCW = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [COL*DEP-1:0]   in_data;
   logic                 arr_rst;
   logic                 arr_valid;
   logic [COL*DEP-1:0]   arr_data;
   logic [COL*DEP-1:0]   res_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [COL*DEP-1:0]   out_data;
   logic                 busy;
   logic [FCW-1:0]       frame_cnt;

   modport master (
      output in_valid, in_data, res_data, out_ready,
      input  in_ready, arr_rst, arr_valid, arr_data, out_valid, out_data, busy, frame_cnt
   );

   modport slave (
      input  in_valid, in_data, res_data, out_ready,
      output in_ready, arr_rst, arr_valid, arr_data, out_valid, out_data, busy, frame_cnt
   );
endinterface

// File: rtl/nn_frame_sequencer.sv
// Buffers one frame and replays it to the MAIN array as one unbroken burst.
// It then waits out the array latency and hands the captured result downstream.
module nn_frame_sequencer #(
   parameter int DEP = 8,
   parameter int COL = 1,
   parameter int INP = 30,
   parameter int LAT = 64,
   parameter int FCW = 16
) (
   input  logic clk,
   input  logic rst,
   nn_frame_sequencer_if.slave bus
);
   localparam int W  = COL * DEP;
   localparam int AW = (INP > 1) ? $clog2(INP) : 1;
   localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [AW-1:0] LAST_BEAT = AW'(INP - 1);
   localparam logic [LW-1:0] LAST_WAIT = LW'(LAT - 1);

   typedef enum logic [2:0] {FILL, CLEAR, FEED, WAIT, OUT} state_t;

   state_t         state;
   logic [AW-1:0]  wcnt;
   logic [AW-1:0]  rcnt;
   logic [AW-1:0]  rnext;
   logic [LW-1:0]  lcnt;
   logic [W-1:0]   frame_buf [INP];

   assign rnext = rcnt + AW'(1);

   always_ff @(posedge clk) begin
      if (state == FILL && bus.in_valid) begin
         frame_buf[wcnt] <= bus.in_data;
      end
   end

   // Array-side outputs are loaded one edge ahead, so that each one is a plain register during its cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= FILL;
         wcnt          <= '0;
         rcnt          <= '0;
         lcnt          <= '0;
         bus.in_ready  <= 1'b1;
         bus.arr_rst   <= 1'b1;
         bus.arr_valid <= 1'b0;
         bus.arr_data  <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.busy      <= 1'b0;
         bus.frame_cnt <= '0;
      end else begin
         unique case (state)
            FILL: begin
               if (bus.in_valid) begin
                  if (wcnt == LAST_BEAT) begin
                     wcnt         <= '0;
                     state        <= CLEAR;
                     bus.in_ready <= 1'b0;
                     bus.busy     <= 1'b1;
                     // For a one-beat frame, beat 0 is still on in_data.
                     bus.arr_data <= (wcnt == '0) ? bus.in_data : frame_buf[0];
                  end else begin
                     wcnt <= wcnt + AW'(1);
                  end
               end
            end
            CLEAR: begin
               state         <= FEED;
               rcnt          <= '0;
               bus.arr_rst   <= 1'b0;
               bus.arr_valid <= 1'b1;
               bus.arr_data  <= frame_buf[0];
            end
            FEED: begin
               if (rcnt == LAST_BEAT) begin
                  state         <= WAIT;
                  lcnt          <= '0;
                  bus.arr_valid <= 1'b0;
                  bus.arr_data  <= '0;
               end else begin
                  rcnt         <= rnext;
                  bus.arr_data <= frame_buf[rnext];
               end
            end
            WAIT: begin
               if (lcnt == LAST_WAIT) begin
                  state         <= OUT;
                  bus.out_data  <= bus.res_data;
                  bus.out_valid <= 1'b1;
                  bus.arr_rst   <= 1'b1;
               end else begin
                  lcnt <= lcnt + LW'(1);
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  state         <= FILL;
                  bus.out_valid <= 1'b0;
                  bus.frame_cnt <= bus.frame_cnt + FCW'(1);
                  bus.in_ready  <= 1'b1;
                  bus.busy      <= 1'b0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_nn_frame_sequencer.sv
// Randomized scoreboard bench for nn_frame_sequencer, with a cycle-timeline reference model.
// The frame counter is narrowed to 3 bits so that it wraps within the run.
module tb_nn_frame_sequencer;
   localparam int DEP = 8;
   localparam int COL = 1;
   localparam int INP = 30;
   localparam int LAT = 4;
   localparam int FCW = 3;
   localparam int W   = COL * DEP;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   nn_frame_sequencer_if #(.DEP(DEP), .COL(COL), .FCW(FCW)) bus ();

   nn_frame_sequencer #(.DEP(DEP), .COL(COL), .INP(INP), .LAT(LAT), .FCW(FCW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] feed_q [$];
   logic [W-1:0] res_q  [$];

   // tl is the position within a frame: 0 idle, 1 clear, 2..INP+1 feed, INP+2..INP+LAT+1 wait.
   int             tl         = 0;
   int             fill_cnt   = 0;
   bit             exp_ov     = 1'b0;
   logic [W-1:0]   exp_od     = '0;
   logic [FCW-1:0] exp_fc     = '0;
   bit             started    = 1'b0;
   bit             beat_taken = 1'b0;
   bit             res_arm    = 1'b0;
   logic [W-1:0]   res_val    = '0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   always @(negedge clk) begin : model
      bit           eir;
      bit           ev;
      bit           ov_now;
      int           cur_tl;
      logic [W-1:0] ead;
      logic [W-1:0] r;
      cur_tl = tl;
      ov_now = exp_ov;
      eir    = (tl == 0) && !exp_ov;
      ev     = (tl >= 2) && (tl <= INP + 1);
      ead    = '0;
      if (started) begin
         if (tl == 1 || ev) begin
            if (feed_q.size() == 0) begin
               timeout_fail("feed_q_empty");
            end else begin
               ead = feed_q[0];
               if (ev) void'(feed_q.pop_front());
            end
         end
         checkOutput("in_ready",  64'(bus.in_ready),  64'(eir));
         checkOutput("busy",      64'(bus.busy),      64'(!eir));
         checkOutput("arr_rst",   64'(bus.arr_rst),   64'(tl < 2));
         checkOutput("arr_valid", 64'(bus.arr_valid), 64'(ev));
         checkOutput("arr_data",  64'(bus.arr_data),  64'(ead));
         checkOutput("out_valid", 64'(bus.out_valid), 64'(exp_ov));
         checkOutput("out_data",  64'(bus.out_data),  64'(exp_od));
         checkOutput("frame_cnt", 64'(bus.frame_cnt), 64'(exp_fc));
      end
      beat_taken = 1'b0;
      if (rst) begin
         started  = 1'b1;
         tl       = 0;
         fill_cnt = 0;
         exp_ov   = 1'b0;
         exp_od   = '0;
         exp_fc   = '0;
         feed_q.delete();
         res_q.delete();
         res_arm <= 1'b0;
      end else if (started) begin
         if (eir && bus.in_valid) begin
            feed_q.push_back(bus.in_data);
            beat_taken = 1'b1;
            fill_cnt++;
            if (fill_cnt == INP) begin
               fill_cnt = 0;
               tl       = 1;
            end
         end else if (tl == INP + LAT + 1) begin
            tl     = 0;
            exp_ov = 1'b1;
            if (res_q.size() == 0) timeout_fail("res_q_empty");
            else exp_od = res_q.pop_front();
         end else if (tl > 0) begin
            tl++;
         end
         if (cur_tl == INP + LAT) begin
            r = W'($urandom) | W'(1);
            res_q.push_back(r);
            res_val <= r;
            res_arm <= 1'b1;
         end else begin
            res_arm <= 1'b0;
         end
         if (ov_now && bus.out_ready) begin
            exp_ov = 1'b0;
            exp_fc = exp_fc + FCW'(1);
         end
      end
   end

   // The array stub presents the result only during the last wait cycle and shows zero at every other time.
   initial begin
      bus.res_data = '0;
      forever begin
         @(negedge clk);
         if (res_arm) bus.res_data = res_val;
         @(posedge clk);
         #1 bus.res_data = '0;
      end
   end

   task automatic applyStimulus(input logic [W-1:0] d, input int gap);
      int n;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!beat_taken && n < 2000);
      if (!beat_taken) timeout_fail("beat_accept");
      #1;
      if (gap > 0) begin
         bus.in_valid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input bit seq, input int gmin, input int gmax, input int nbeats, input int base);
      for (int i = 0; i < nbeats; i++) begin
         applyStimulus(seq ? W'(base + i) : W'($urandom), int'($urandom_range(gmax, gmin)));
      end
   endtask

   task automatic wait_result();
      int n = 0;
      while (!exp_ov && n < 3000) begin
         @(posedge clk);
         n++;
      end
      if (!exp_ov) timeout_fail("wait_result");
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(tl == 0 && !exp_ov && fill_cnt == 0) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      if (n >= 3000) timeout_fail("wait_idle");
      #1;
   endtask

   initial begin
      int n;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] sequential frame, back to back");
      send_frame(1'b1, 0, 0, INP, 1);
      bus.in_valid = 1'b0;
      wait_idle();

      $display("[TB] sequential frame with 3-cycle gaps");
      send_frame(1'b1, 3, 3, INP, 1);
      wait_idle();

      $display("[TB] result held with out_ready low");
      bus.out_ready = 1'b0;
      send_frame(1'b0, 0, 2, INP, 0);
      bus.in_valid = 1'b0;
      wait_result();
      repeat (10) @(posedge clk);
      #1 bus.out_ready = 1'b1;
      wait_idle();
      send_frame(1'b0, 0, 1, INP, 0);
      bus.in_valid = 1'b0;
      wait_idle();

      $display("[TB] reset during feed");
      send_frame(1'b0, 0, 0, INP, 0);
      bus.in_valid = 1'b0;
      n = 0;
      while (tl != 14 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (tl != 14) timeout_fail("reach_feed_12");
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      send_frame(1'b0, 0, 1, INP, 0);
      bus.in_valid = 1'b0;
      wait_idle();

      $display("[TB] 31 beats offered with in_valid held high");
      send_frame(1'b1, 0, 0, INP + 1, 64);
      send_frame(1'b1, 0, 0, INP - 1, 128);
      bus.in_valid = 1'b0;
      wait_idle();

      $display("[TB] random frames and random result stalls");
      for (int f = 0; f < 8; f++) begin
         bus.out_ready = 1'b0;
         send_frame(1'b0, 0, 2, INP, 0);
         bus.in_valid = 1'b0;
         wait_result();
         repeat ($urandom_range(5, 0)) @(posedge clk);
         #1 bus.out_ready = 1'b1;
         wait_idle();
      end

      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/nn_frame_sequencer.md
Name: nn_frame_sequencer

Overview:
- Controller in front of the MAIN systolic inference datapath.
- Accepts one input frame of INP samples over a valid/ready stream that may stall, and buffers the whole frame.
- Drives MAIN's reset and data_in with the exact contiguous, one-sample-per-cycle sequence MAIN requires, then waits a fixed pipeline latency.
- Captures data_out and returns it over a valid/ready result handshake.

Parameters:
DEP, 8, bits per lane sample (matches MAIN DEP)
COL, 1, lanes per beat (matches MAIN COL)
INP, 30, samples (beats) per frame
LAT, 64, cycles from the last fed beat until MAIN data_out is valid
FCW, 16, frame counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream beat valid
in_ready  out  1  sequencer accepts a beat (high only in FILL)
in_data  in  COL*DEP  upstream beat, lane c at bits [c*DEP +: DEP]
arr_rst  out  1  drives MAIN rst
arr_valid  out  1  high on cycles carrying a real frame beat to MAIN
arr_data  out  COL*DEP  drives MAIN data_in (same lane packing)
res_data  in  COL*DEP  MAIN data_out
out_valid  out  1  result held valid
out_ready  in  1  downstream accepts result
out_data  out  COL*DEP  captured result
busy  out  1  state is not FILL
frame_cnt  out  FCW  completed (accepted) frames, wraps at 2^FCW

Behaviour:
- Clocking and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset values:
  - state=FILL, wcnt=0, rcnt=0
  - in_ready=1, arr_rst=1, arr_valid=0, arr_data=0
  - out_valid=0, out_data=0, busy=0, frame_cnt=0
  - Buffer contents are don't-care.
- Storage: frame buffer of INP x COL*DEP. Write pointer wcnt, read pointer rcnt, wait counter; each counter is clog2 of its range, min 1 bit.
- Output timing: all array-side outputs are Moore, registered or decoded from registered state/counters. No combinational path from in_valid or out_ready to arr_*.
- FILL:
  - in_ready=1, arr_rst=1, arr_valid=0, arr_data=0.
  - Each cycle with in_valid&in_ready: buf[wcnt]<=in_data, wcnt++.
  - On accepting beat INP-1: next state CLEAR, wcnt<=0.
  - Gaps in in_valid simply pause the fill.
- CLEAR (exactly 1 cycle): arr_rst=1, arr_data=buf[0], arr_valid=0, in_ready=0. Next state FEED, rcnt=0.
- FEED (exactly INP cycles, never stalls):
  - arr_rst=0, arr_valid=1, arr_data=buf[rcnt], rcnt++.
  - After cycle INP-1: next state WAIT, wait counter=0.
- WAIT (exactly LAT cycles): arr_rst=0, arr_valid=0, arr_data=0.
  - At the clock edge ending the last WAIT cycle: out_data<=res_data, out_valid<=1, next state OUT.
  - Result is therefore sampled LAT cycles after the last FEED cycle.
- OUT:
  - arr_rst=1, arr_data=0, in_ready=0.
  - out_valid and out_data are held stable until out_valid&out_ready.
  - On that edge: out_valid<=0, frame_cnt++, next state FILL.
  - in_ready=1 is first seen the following cycle. There is no same-cycle accept of a new beat.
- busy=1 in CLEAR, FEED, WAIT and OUT.
- Boundaries:
  - in_valid while in_ready=0 is ignored (not consumed).
  - out_ready while out_valid=0 is ignored.
  - out_ready held high from entry to OUT gives a 1-cycle OUT.
  - frame_cnt wraps 2^FCW-1 -> 0.
- Reset mid-operation (any state): on the next edge, all reset values apply. A partially filled frame or pending result is discarded; arr_rst=1 immediately.
- Degenerate sizes: INP=1 gives FEED of 1 cycle; LAT=1 gives WAIT of 1 cycle. Both are legal.

Test Plan:
- Reset, then back-to-back beats 0x01..0x1E (INP=30): in_ready falls after the 30th accept. One cycle of arr_rst=1 with arr_data=0x01. Then 30 cycles of arr_rst=0, arr_valid=1, arr_data=0x01..0x1E in order. Then arr_data=0x00.
- Same frame with in_valid low 3 cycles between every beat: the FEED window is still 30 contiguous cycles with identical data.
- LAT=4: stub res_data=0xA5 only in the 4th cycle after the last FEED cycle, 0x00 otherwise. Required: out_data=0xA5, out_valid rising the following cycle.
- out_ready=0 for 10 cycles in OUT: out_valid and out_data held, in_ready=0, arr_rst=1. Raise out_ready: frame_cnt 0->1, in_ready=1 next cycle, then a second frame completes and frame_cnt=2.
- rst pulsed during FEED beat 12: next cycle arr_rst=1, arr_valid=0, out_valid=0, frame_cnt=0, in_ready=1. A fresh 30-beat frame then sequences correctly.
- in_valid held high continuously with 31 beats offered: exactly 30 accepted. The 31st is accepted only after the OUT handshake and lands in buf[0] of the next frame.
